// File: rtl/times_table_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : times_table_loader_pkg
//  Description : Shared definitions for the times-table loader: FSM state
//                encoding, table size, AXI response code and retry limit.
//  Config      : TT_LOADER_RETRY_EN (consumed by times_table_loader)
//  Revision    : 1.0  initial release
// ============================================================================
package times_table_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        RESP   = 2'd2,
        FINISH = 2'd3
    } tt_state_t;

    // 3-bit x 3-bit table, indexed by idx = {a, b}
    localparam int          TT_ENTRIES = 64;
    localparam int          c_IDX_W    = 6;
    localparam logic [5:0]  c_LAST_IDX = 6'(TT_ENTRIES - 1);

    // AXI write response code for success
    localparam logic [1:0]  OKAY       = 2'b00;

    // Extra attempts allowed per entry when retry is enabled
    localparam int          MAX_RETRY  = 2;
    localparam int          c_RETRY_W  = 2;

endpackage : times_table_loader_pkg
`default_nettype wire

// File: rtl/tt_entry_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tt_entry_gen
//  Description : Combinational mapping of a table index to its AXI write
//                address and data word. idx = {a, b}; address is the
//                word-aligned byte address idx*4, data is a*b.
//  Ports       : i_idx     - 6-bit table index
//                o_awaddr  - byte address, zero-extended to ADDR_W
//                o_wdata   - product in bits [5:0], upper bits zero
//  Revision    : 1.0  initial release
// ============================================================================
module tt_entry_gen
    import times_table_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic [c_IDX_W-1:0] i_idx,
    output logic [ADDR_W-1:0]  o_awaddr,
    output logic [DATA_W-1:0]  o_wdata
);

    logic [2:0]         w_a;
    logic [2:0]         w_b;
    logic [5:0]         w_prod;
    logic [c_IDX_W+1:0] w_byte_addr;

    assign w_a         = i_idx[5:3];
    assign w_b         = i_idx[2:0];

    // Operands widened first so the full 6-bit product (max 49) is kept
    assign w_prod      = {3'b000, w_a} * {3'b000, w_b};

    assign w_byte_addr = {i_idx, 2'b00};

    assign o_awaddr    = ADDR_W'(w_byte_addr);
    assign o_wdata     = DATA_W'(w_prod);

endmodule : tt_entry_gen
`default_nettype wire

// File: rtl/times_table_loader.sv
`default_nettype none
// ============================================================================
//  Module      : times_table_loader
//  Description : Writes the 64-entry 3x3-bit multiplication table into a
//                downstream AXI4-Lite memory, one write at a time, on a
//                start request. A sticky err flag records any non-OKAY
//                write response.
//  Config      : TT_LOADER_RETRY_EN - when defined, a failing entry is
//                re-issued up to MAX_RETRY extra times before err is set.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start/busy/done    - control: request, in-progress, pulse
//                err                - sticky non-OKAY response flag
//                aw*/w*/b*          - AXI4-Lite write channels (master)
//  Revision    : 1.0  initial release
// ============================================================================
module times_table_loader
    import times_table_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // control
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    // write address channel
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    // write data channel
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    // write response channel
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    tt_state_t          r_state;
    tt_state_t          w_state_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic               r_aw_done;
    logic               w_aw_done_nxt;
    logic               r_w_done;
    logic               w_w_done_nxt;
    logic               r_err;
    logic               w_err_nxt;

    logic               w_aw_fire;
    logic               w_w_fire;
    logic               w_aw_fin;
    logic               w_w_fin;
    logic               w_bad_resp;

`ifdef TT_LOADER_RETRY_EN
    logic [c_RETRY_W-1:0] r_retry;
    logic [c_RETRY_W-1:0] w_retry_nxt;
`endif

    // ------------------------------------------------------------------
    // Address/data generation. Both outputs depend only on r_idx, which
    // is frozen for the whole WRITE phase, so they are stable while the
    // corresponding valid is high.
    // ------------------------------------------------------------------
    tt_entry_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_entry_gen (
        .i_idx    (r_idx),
        .o_awaddr (awaddr),
        .o_wdata  (wdata)
    );

    assign wstrb = '1;
    assign err   = r_err;

    // Each channel is finished once its handshake has happened, either in
    // an earlier cycle (r_*_done) or in the current one (fire).
    assign w_aw_fire  = (r_state == WRITE) && !r_aw_done && awready;
    assign w_w_fire   = (r_state == WRITE) && !r_w_done  && wready;
    assign w_aw_fin   = r_aw_done || w_aw_fire;
    assign w_w_fin    = r_w_done  || w_w_fire;
    assign w_bad_resp = (bresp != OKAY);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

`ifdef TT_LOADER_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry <= '0;
        end else begin
            r_retry <= w_retry_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_err_nxt     = r_err;
`ifdef TT_LOADER_RETRY_EN
        w_retry_nxt   = r_retry;
`endif
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_idx_nxt     = '0;
                    w_err_nxt     = 1'b0;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
`ifdef TT_LOADER_RETRY_EN
                    w_retry_nxt   = '0;
`endif
                    w_state_nxt   = WRITE;
                end
            end

            WRITE: begin
                busy    = 1'b1;
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
                if (w_aw_fin && w_w_fin) begin
                    // Done flags are cleared here so the next WRITE entry
                    // starts with both valids asserted.
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_state_nxt   = RESP;
                end else begin
                    w_aw_done_nxt = w_aw_fin;
                    w_w_done_nxt  = w_w_fin;
                end
            end

            RESP: begin
                busy   = 1'b1;
                bready = 1'b1;
                if (bvalid) begin
`ifdef TT_LOADER_RETRY_EN
                    if (w_bad_resp && (r_retry < c_RETRY_W'(MAX_RETRY))) begin
                        // Re-issue the same entry; idx is left untouched.
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = WRITE;
                    end else begin
                        if (w_bad_resp) begin
                            w_err_nxt = 1'b1;
                        end
                        w_retry_nxt = '0;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = FINISH;
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                            w_state_nxt = WRITE;
                        end
                    end
`else
                    if (w_bad_resp) begin
                        w_err_nxt = 1'b1;
                    end
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = WRITE;
                    end
`endif
                end
            end

            FINISH: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule : times_table_loader
`default_nettype wire

// File: tb/tb_times_table_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_times_table_loader
//  Description : Directed self-checking bench for times_table_loader. A
//                small AXI4-Lite slave records every write into a shadow
//                table; each scenario task compares the recorded results
//                against hand-derived expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_times_table_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                busy;
    logic                done;
    logic                err;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    int checks = 0;
    int errors = 0;

    // results captured by the slave model
    logic [DATA_W-1:0] mem [64];
    int                wr_cnt [64];
    int                b_cnt;
    int                done_cyc;
    int                addr_unstable;
    int                wfirst_seen;
    int                timed_out;
    int                stopped;
    int                first_addr_seen;
    logic [ADDR_W-1:0] first_addr;
    logic              err_at_done;

    times_table_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    // Runs one fill against a slave model. Everything is sampled and driven
    // on the falling edge. aw_dly/w_dly: cycles a valid waits before ready.
    // fail_idx/fail_cnt: the first fail_cnt attempts at fail_idx get SLVERR.
    // stop_idx >= 0: return while the DUT waits in RESP for that entry.
    task automatic drive_fill(input int aw_dly, input int w_dly,
                              input int fail_idx, input int fail_cnt,
                              input bit hold_start, input int stop_idx);
        bit                p_aw = 1'b0;
        bit                p_w  = 1'b0;
        bit                p_b  = 1'b0;
        bit                got_aw = 1'b0;
        bit                got_w  = 1'b0;
        bit                b_pend = 1'b0;
        bit                prev_awv = 1'b0;
        logic [ADDR_W-1:0] cap_addr  = '0;
        logic [ADDR_W-1:0] prev_addr = '0;
        logic [DATA_W-1:0] cap_data  = '0;
        logic [1:0]        b_resp    = 2'b00;
        int                aw_cnt = 0;
        int                w_cnt  = 0;
        int                last_idx = -1;
        int                k;
        for (int i = 0; i < 64; i++) begin
            mem[i]    = '0;
            wr_cnt[i] = 0;
        end
        b_cnt = 0; done_cyc = 0; addr_unstable = 0; wfirst_seen = 0;
        timed_out = 1; stopped = 0; first_addr_seen = 0; first_addr = '0;
        err_at_done = 1'b0;

        @(negedge clk);
        start = 1'b1; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            // handshakes completed on the preceding rising edge
            if (p_aw) got_aw = 1'b1;
            if (p_w)  got_w  = 1'b1;
            if (p_b) begin
                b_cnt++;
                b_pend = 1'b0;
            end
            if (got_aw && got_w && !b_pend) begin
                k = int'(cap_addr >> 2);
                mem[k] = cap_data;
                wr_cnt[k]++;
                last_idx = k;
                b_resp = (k == fail_idx && wr_cnt[k] <= fail_cnt) ? 2'b10 : 2'b00;
                b_pend = 1'b1;
                got_aw = 1'b0;
                got_w  = 1'b0;
            end
            if (done === 1'b1) begin
                done_cyc = cyc; err_at_done = err; timed_out = 0;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                break;
            end
            if (stop_idx >= 0 && bready === 1'b1 && last_idx == stop_idx) begin
                stopped = 1; timed_out = 0;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                break;
            end
            if (awvalid === 1'b1 && first_addr_seen == 0) begin
                first_addr_seen = 1;
                first_addr = awaddr;
            end
            if (prev_awv && awvalid === 1'b1 && awaddr !== prev_addr) addr_unstable++;
            if (awvalid === 1'b1 && wvalid === 1'b0) wfirst_seen = 1;

            awready = (awvalid === 1'b1) && (aw_cnt >= aw_dly);
            wready  = (wvalid === 1'b1) && (w_cnt >= w_dly);
            bvalid  = b_pend;
            bresp   = b_pend ? b_resp : 2'b00;

            p_aw = (awvalid === 1'b1) && awready;
            p_w  = (wvalid === 1'b1) && wready;
            p_b  = bvalid && (bready === 1'b1);
            if (p_aw) cap_addr = awaddr;
            if (p_w)  cap_data = wdata;

            if (awvalid === 1'b1 && !awready) aw_cnt++; else aw_cnt = 0;
            if (wvalid === 1'b1 && !wready)   w_cnt++;  else w_cnt = 0;
            prev_awv  = (awvalid === 1'b1) && !awready;
            prev_addr = awaddr;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valids: got %b expected 000", {awvalid, wvalid, bready});
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got %b expected 000", {busy, done, err});
        end
        checks++;
        if (awaddr !== '0) begin
            errors++;
            $display("FAIL reset_awaddr: got %h expected 0", awaddr);
        end
        checks++;
        if (wdata !== '0) begin
            errors++;
            $display("FAIL reset_wdata: got %h expected 0", wdata);
        end
        checks++;
        if (wstrb !== 4'hF) begin
            errors++;
            $display("FAIL reset_wstrb: got %h expected f", wstrb);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ready_fill();
        int bad = 0;
        int dup = 0;
        logic [DATA_W-1:0] exp;
        drive_fill(0, 0, -1, 0, 1'b0, -1);
        for (int i = 0; i < 64; i++) begin
            exp = DATA_W'((i >> 3) * (i & 7));
            if (mem[i] !== exp) bad++;
            if (wr_cnt[i] != 1) dup++;
        end
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL ready_timeout: got %0d expected 0", timed_out);
        end
        checks++;
        if (done_cyc != 129) begin
            errors++;
            $display("FAIL ready_done_cycle: got %0d expected 129", done_cyc);
        end
        checks++;
        if (err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL ready_err: got %b expected 0", err_at_done);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ready_table: got %0d wrong entries expected 0", bad);
        end
        checks++;
        if (mem[59] !== 32'd21) begin
            errors++;
            $display("FAIL ready_entry_0xEC: got %0d expected 21", mem[59]);
        end
        checks++;
        if (dup != 0 || b_cnt != 64) begin
            errors++;
            $display("FAIL ready_write_count: got dup=%0d b=%0d expected dup=0 b=64", dup, b_cnt);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ready_done_pulse: got done,busy=%b expected 00", {done, busy});
        end
    endtask

    task automatic test_delayed_aw();
        int bad = 0;
        int dup = 0;
        logic [DATA_W-1:0] exp;
        drive_fill(3, 0, -1, 0, 1'b0, -1);
        for (int i = 0; i < 64; i++) begin
            exp = DATA_W'((i >> 3) * (i & 7));
            if (mem[i] !== exp) bad++;
            if (wr_cnt[i] != 1) dup++;
        end
        checks++;
        if (timed_out != 0 || done_cyc != 321) begin
            errors++;
            $display("FAIL delay_done_cycle: got %0d (timeout %0d) expected 321", done_cyc, timed_out);
        end
        checks++;
        if (wfirst_seen != 1) begin
            errors++;
            $display("FAIL delay_wvalid_first: got %0d expected 1", wfirst_seen);
        end
        checks++;
        if (addr_unstable != 0) begin
            errors++;
            $display("FAIL delay_awaddr_stable: got %0d changes expected 0", addr_unstable);
        end
        checks++;
        if (bad != 0 || dup != 0 || b_cnt != 64) begin
            errors++;
            $display("FAIL delay_table: got bad=%0d dup=%0d b=%0d expected 0 0 64", bad, dup, b_cnt);
        end
        checks++;
        if (err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL delay_err: got %b expected 0", err_at_done);
        end
    endtask

    task automatic test_bresp_err();
        int bad = 0;
        logic [DATA_W-1:0] exp;
`ifdef TT_LOADER_RETRY_EN
        logic exp_err   = 1'b0;
        int   exp_wr5   = 3;
        int   exp_cyc   = 133;
`else
        logic exp_err   = 1'b1;
        int   exp_wr5   = 1;
        int   exp_cyc   = 129;
`endif
        drive_fill(0, 0, 5, 2, 1'b0, -1);
        for (int i = 0; i < 64; i++) begin
            exp = DATA_W'((i >> 3) * (i & 7));
            if (mem[i] !== exp) bad++;
        end
        checks++;
        if (timed_out != 0 || done_cyc != exp_cyc) begin
            errors++;
            $display("FAIL bresp_done_cycle: got %0d (timeout %0d) expected %0d", done_cyc, timed_out, exp_cyc);
        end
        checks++;
        if (wr_cnt[5] != exp_wr5) begin
            errors++;
            $display("FAIL bresp_idx5_writes: got %0d expected %0d", wr_cnt[5], exp_wr5);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bresp_table: got %0d wrong entries expected 0", bad);
        end
        @(negedge clk);
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL bresp_err_sticky: got %b expected %b", err, exp_err);
        end
    endtask

    task automatic test_reset_abort();
        int bad = 0;
        logic [DATA_W-1:0] exp;
        drive_fill(0, 0, -1, 0, 1'b0, 20);
        checks++;
        if (stopped != 1) begin
            errors++;
            $display("FAIL abort_reach_idx20: got %0d expected 1", stopped);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_outputs: got %b expected 0000", {awvalid, wvalid, bready, busy});
        end
        rst = 1'b0;
        drive_fill(0, 0, -1, 0, 1'b0, -1);
        for (int i = 0; i < 64; i++) begin
            exp = DATA_W'((i >> 3) * (i & 7));
            if (mem[i] !== exp) bad++;
        end
        checks++;
        if (first_addr_seen != 1 || first_addr !== 8'h00) begin
            errors++;
            $display("FAIL abort_restart_addr: got %h (seen %0d) expected 00", first_addr, first_addr_seen);
        end
        checks++;
        if (done_cyc != 129 || bad != 0) begin
            errors++;
            $display("FAIL abort_refill: got cycle=%0d bad=%0d expected 129 0", done_cyc, bad);
        end
    endtask

    task automatic test_start_held();
        int dup = 0;
`ifdef TT_LOADER_RETRY_EN
        int exp_wr5 = 3;
`else
        int exp_wr5 = 1;
`endif
        drive_fill(0, 0, 5, 3, 1'b1, -1);
        for (int i = 0; i < 64; i++) begin
            if (i != 5 && wr_cnt[i] != 1) dup++;
        end
        checks++;
        if (timed_out != 0 || dup != 0 || wr_cnt[5] != exp_wr5) begin
            errors++;
            $display("FAIL held_no_restart: got dup=%0d wr5=%0d timeout=%0d expected 0 %0d 0", dup, wr_cnt[5], timed_out, exp_wr5);
        end
        checks++;
        if (err_at_done !== 1'b1) begin
            errors++;
            $display("FAIL held_err_first: got %b expected 1", err_at_done);
        end
        // start is still high: the next fill begins straight from IDLE
        drive_fill(0, 0, -1, 0, 1'b0, -1);
        checks++;
        if (done_cyc != 129 || err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL held_second_fill: got cycle=%0d err=%b expected 129 0", done_cyc, err_at_done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ready_fill();
        test_delayed_aw();
        test_bresp_err();
        test_reset_abort();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_times_table_loader
`default_nettype wire
